// File: rtl/sobel_window_gen_pkg.sv
// Shared types and constants for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int WIN_TAPS = 9;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {FILL_S, RUN_S} win_state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out valid-ready bus of the window generator.
interface sobel_window_gen_if #(
  parameter int WIDTH_P = 8
);
  import sobel_pkg::*;

  logic                          valid_i;
  logic                          ready_o;
  logic [WIDTH_P-1:0]            data_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [WIN_TAPS*WIDTH_P-1:0]   window_o;
  logic                          last_o;

  // Block side: consumes pixels, produces windows.
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, window_o, last_o
  );

  // Environment side: pixel source plus window sink.
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, window_o, last_o
  );

endinterface

// File: rtl/sobel_window_gen_linebuf.sv
// One row delay: IMG_W_P-deep RAM, async read, sync write, shared address.
// Contents are deliberately not reset; the top's fill phase hides stale data.
module sobel_linebuf #(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(IMG_W_P)-1:0] addr,
  input  logic [WIDTH_P-1:0]         wdata,
  output logic [WIDTH_P-1:0]         rdata
);

  logic [WIDTH_P-1:0] mem [IMG_W_P];

  // Read returns the old word even in a write cycle (read-before-write).
  assign rdata = mem[addr];

  // Store the new pixel for this column.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds full-interior 3x3 windows from a raster pixel stream.
// Two line delays supply the two previous rows; a 3x3 tap array slides over them.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640,
  parameter int IMG_H_P = 480
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sobel_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W_P);
  localparam int RW = $clog2(IMG_H_P);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_P - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_P - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  win_state_e              state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    valid_q;
  logic                    last_q;
  logic                    ready;
  logic                    acc;
  logic                    col_end;
  logic                    frame_end;
  logic                    emit;
  logic [WIDTH_P-1:0]      l1_rd;
  logic [WIDTH_P-1:0]      l2_rd;
  // tap[r][c]: r=0 oldest row, c=0 oldest column.
  logic [2:0][2:0][WIDTH_P-1:0] tap;

  // One output register, so a consumed window frees the slot in the same cycle.
  assign ready     = ~valid_q | bus.ready_i;
  assign acc       = bus.valid_i & ready;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end && (row == ROW_LAST);
  // Windows ending at col 0/1 straddle a row boundary and are dropped.
  assign emit      = acc && (state == RUN_S) && (col >= COL_TWO);

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid_q;
  assign bus.last_o   = last_q;
  // Packed [r][c] layout already places tap (r,c) at bit (3*r+c)*WIDTH_P.
  assign bus.window_o = tap;

  sobel_linebuf #(.WIDTH_P(WIDTH_P), .IMG_W_P(IMG_W_P)) u_line1 (
    .clk   (clk_i),
    .we    (acc),
    .addr  (col),
    .wdata (bus.data_i),
    .rdata (l1_rd)
  );

  sobel_linebuf #(.WIDTH_P(WIDTH_P), .IMG_W_P(IMG_W_P)) u_line2 (
    .clk   (clk_i),
    .we    (acc),
    .addr  (col),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  // Raster counters, fill/run phase and the output valid/last register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FILL_S;
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (acc) begin
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        case (state)
          FILL_S: if (col_end && (row == ROW_ONE)) state <= RUN_S;
          RUN_S:  if (frame_end) state <= FILL_S;
          default: state <= FILL_S;
        endcase
      end
      if (emit) begin
        valid_q <= 1'b1;
        last_q  <= frame_end;
      end else if (bus.ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  // Slide the taps left on each accepted pixel; new column is {line2, line1, input}.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap <= '0;
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= tap[r][1];
        tap[r][1] <= tap[r][2];
      end
      tap[0][2] <= l2_rd;
      tap[1][2] <= l1_rd;
      tap[2][2] <= bus.data_i;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image of 8-bit pixels.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.WIDTH_P(W)) bus ();

  sobel_window_gen #(.WIDTH_P(W), .IMG_W_P(IW), .IMG_H_P(IH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [71:0] w;
    logic        last;
  } win_t;

  win_t       exp_q[$];
  logic [7:0] pix_q[$];
  int total = 0;
  int passed = 0;
  int n_acc, n_win, n_last, first_acc;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: a frame is a 2D array; every interior 3x3 neighbourhood is one window.
  task automatic push_frame(input bit rnd);
    logic [7:0] f[IH][IW];
    win_t e;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        f[r][c] = rnd ? 8'($urandom) : 8'(4 * r + c);
        pix_q.push_back(f[r][c]);
      end
    for (int r = 2; r < IH; r++)
      for (int c = 2; c < IW; c++) begin
        e.w = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            e.w[(3 * rr + cc) * W +: W] = f[r - 2 + rr][c - 2 + cc];
        e.last = (r == IH - 1) && (c == IW - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pix_q.delete();
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, observe what will transfer at the next posedge.
  task automatic step(input bit v, input bit rdy);
    @(negedge clk);
    bus.valid_i = v && (pix_q.size() > 0);
    bus.data_i  = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
    bus.ready_i = rdy;
    #1;
    if (bus.valid_o && first_acc < 0) first_acc = n_acc;
    if (bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) chk("extra_window", 72'(bus.valid_o), 72'(0));
      else begin
        chk("window", bus.window_o, exp_q[0].w);
        chk("last", 72'(bus.last_o), 72'(exp_q[0].last));
        n_win++;
        if (exp_q[0].last) n_last++;
        void'(exp_q.pop_front());
      end
    end
    if (bus.valid_i && bus.ready_o) begin
      void'(pix_q.pop_front());
      n_acc++;
    end
  endtask

  task automatic run(input int vp, input int rp, input int budget);
    int cyc = 0;
    n_win = 0;
    n_last = 0;
    first_acc = -1;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      step($urandom_range(99) < vp, $urandom_range(99) < rp);
      cyc++;
    end
    chk("drained", 72'(exp_q.size()), 72'(0));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.data_i  = '0;
    n_acc = 0;
    first_acc = -1;

    // 1: reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 72'(bus.valid_o), 72'(0));
    chk("rst_last", 72'(bus.last_o), 72'(0));
    chk("rst_ready", 72'(bus.ready_o), 72'(1));
    chk("rst_window", bus.window_o, 72'(0));

    // 2: one frame back-to-back
    n_acc = 0;
    push_frame(1'b0);
    run(100, 100, 200);
    chk("t2_first_lat", 72'(first_acc), 72'(11));
    chk("t2_wins", 72'(n_win), 72'(4));
    chk("t2_lasts", 72'(n_last), 72'(1));

    // 3: downstream stall while first window is valid
    do_reset();
    n_acc = 0;
    first_acc = -1;
    push_frame(1'b0);
    for (int k = 0; k < 50 && !(bus.valid_o === 1'b1); k++) step(1'b1, 1'b0);
    chk("t3_stall_acc", 72'(n_acc), 72'(11));
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      chk("t3_hold_valid", 72'(bus.valid_o), 72'(1));
      chk("t3_hold_win", bus.window_o, exp_q[0].w);
      chk("t3_hold_ready", 72'(bus.ready_o), 72'(0));
      chk("t3_hold_acc", 72'(n_acc), 72'(11));
    end
    run(100, 100, 200);
    chk("t3_wins", 72'(n_win), 72'(4));

    // 4: two frames back-to-back
    n_acc = 0;
    push_frame(1'b0);
    push_frame(1'b0);
    run(100, 100, 400);
    chk("t4_wins", 72'(n_win), 72'(8));
    chk("t4_lasts", 72'(n_last), 72'(2));
    chk("t4_first_lat", 72'(first_acc), 72'(11));

    // 5: reset mid-frame after 7 pixels
    do_reset();
    push_frame(1'b0);
    n_win = 0;
    repeat (7) step(1'b1, 1'b1);
    chk("t5_no_win_partial", 72'(n_win), 72'(0));
    do_reset();
    n_acc = 0;
    push_frame(1'b0);
    run(100, 100, 200);
    chk("t5_first_lat", 72'(first_acc), 72'(11));
    chk("t5_wins", 72'(n_win), 72'(4));

    // 6: random data, random valid gaps and ready toggling, 3 frames
    for (int f = 0; f < 3; f++) push_frame(1'b1);
    run(70, 60, 3000);
    chk("t6_wins", 72'(n_win), 72'(12));
    chk("t6_lasts", 72'(n_last), 72'(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
